// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the multi-cycle MEM-stage data responder.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        DMR_IDLE = 2'd0,
        DMR_BUSY = 2'd1,
        DMR_DONE = 2'd2
    } dmr_state_e;

    localparam int DMR_WORD_BYTES = 4;

    // Error code is a bit mask so a misaligned, out-of-range access records both causes.
    localparam logic [1:0] DMR_ERR_NONE     = 2'b00;
    localparam logic [1:0] DMR_ERR_MISALIGN = 2'b01;
    localparam logic [1:0] DMR_ERR_RANGE    = 2'b10;

endpackage

// File: rtl/dmr_word_array.sv
// Word storage for the data responder: one synchronous write port, one synchronous read port.
module dmr_word_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
    output logic [DATA_W-1:0]        rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: no reset on the storage or its read register, so this maps onto block RAM;
    // the owner masks the read data until a real load has completed.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data responder: latches one load/store, holds the pipeline for LATENCY+1 cycles,
// then completes the access against the word array in a single DONE cycle.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              memRead_i,
    input  logic              memWrite_i,
    input  logic [DATA_W-1:0] Write_Data_i,
    output logic [DATA_W-1:0] Read_Data_o,
    output logic              stall_o,
    output logic              err_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(DMR_WORD_BYTES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    generate
        if (LATENCY < 1) begin : g_latency_check
            $error("data_mem_responder: LATENCY must be at least 1");
        end
    endgenerate

    dmr_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              is_write_q, is_write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        err_q, err_d;
    logic              rd_zero_q, rd_zero_d;

    logic              req;
    logic              misaligned;
    logic              out_of_range;
    logic              stall_raw;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] array_rd_data;

    assign req          = memRead_i | memWrite_i;
    assign misaligned   = |addr_i[OFF_W-1:0];
    assign out_of_range = (addr_i >> (IDX_W + OFF_W)) != '0;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        is_write_d = is_write_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rd_zero_d  = rd_zero_q;
        stall_raw  = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;

        unique case (state_q)
            DMR_IDLE: begin
                if (req) begin
                    stall_raw  = 1'b1;
                    idx_d      = addr_i[IDX_W+OFF_W-1:OFF_W];
                    is_write_d = memWrite_i;
                    wdata_d    = Write_Data_i;
                    err_d      = (misaligned   ? DMR_ERR_MISALIGN : DMR_ERR_NONE)
                               | (out_of_range ? DMR_ERR_RANGE    : DMR_ERR_NONE);
                    cnt_d      = CNT_INIT;
                    state_d    = DMR_BUSY;
                end
            end
            DMR_BUSY: begin
                stall_raw = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = DMR_DONE;
                    // Out-of-range stores are dropped; out-of-range loads read as zero.
                    if ((err_q & DMR_ERR_RANGE) == DMR_ERR_NONE) begin
                        wr_en     = is_write_q;
                        rd_en     = !is_write_q;
                        rd_zero_d = is_write_q ? rd_zero_q : 1'b0;
                    end else if (!is_write_q) begin
                        rd_zero_d = 1'b1;
                    end
                end
            end
            DMR_DONE: begin
                state_d = DMR_IDLE;
            end
            default: begin
                state_d = DMR_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= DMR_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            is_write_q <= 1'b0;
            wdata_q    <= '0;
            err_q      <= DMR_ERR_NONE;
            rd_zero_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            is_write_q <= is_write_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rd_zero_q  <= rd_zero_d;
        end
    end

    dmr_word_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_word_array (
        .clk_i     (clk_i),
        .wr_en_i   (wr_en),
        .wr_idx_i  (idx_q),
        .wr_data_i (wdata_q),
        .rd_en_i   (rd_en),
        .rd_idx_i  (idx_q),
        .rd_data_o (array_rd_data)
    );

    // Gating with rst_i drops the stall as soon as reset asserts, even with a request present.
    assign stall_o     = stall_raw & ~rst_i;
    assign err_o       = (state_q == DMR_DONE) && (err_q != DMR_ERR_NONE);
    assign Read_Data_o = rd_zero_q ? '0 : array_rd_data;

endmodule
